iob_dma_sched: RTL and testbench

IOB_DMA_SCHED -- requirements
Module: iob_dma_sched

---
 rtl/iob_dma_pkg.sv | 12 +
 rtl/iob_dma_rr_arb.sv | 38 +++
 rtl/iob_dma_sched.sv | 144 ++++++++++++++
 tb/tb_iob_dma_sched.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_dma_pkg.sv
// Shared definitions for the DMA burst scheduler: channel state encoding and page size.
package iob_dma_pkg;

    typedef enum logic [1:0] {
        CH_IDLE  = 2'd0,
        CH_ISSUE = 2'd1,
        CH_DRAIN = 2'd2
    } ch_state_t;

    localparam int PAGE_BYTES = 4096;

endpackage

// File: rtl/iob_dma_rr_arb.sv
// Round-robin arbiter: grants the first requester at or after the pointer;
// the pointer moves past the granted index only when adv is strobed.
module iob_dma_rr_arb #(
    parameter int N = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [N-1:0]                         req,
    input  logic                                 adv,
    output logic [N-1:0]                         gnt,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] gnt_idx
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] ptr;
    int            j;

    // Scan from the farthest candidate back to ptr so the nearest requester wins.
    always_comb begin
        gnt_idx = '0;
        j       = 0;
        for (int i = N - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (req[j]) gnt_idx = IW'(j);
        end
        gnt = (|req) ? (N'(1) << gnt_idx) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (adv) begin
            ptr <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/iob_dma_sched.sv
// Multi-channel DMA burst scheduler. Define IOB_DMA_SCHED_4K_EN to keep bursts
// from crossing 4 KiB address boundaries.
module iob_dma_sched
    import iob_dma_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 24,
    parameter int MAX_BURST = 16,
    parameter int MAX_OUTST = 2
) (
    input  logic                                    clk_i,
    input  logic                                    arst_n_i,
    input  logic                                    cke_i,
    input  logic [N_CH-1:0]                         cfg_valid_i,
    output logic [N_CH-1:0]                         cfg_ready_o,
    input  logic [N_CH*ADDR_W-1:0]                  cfg_addr_i,
    input  logic [N_CH*LEN_W-1:0]                   cfg_len_i,
    input  logic [N_CH-1:0]                         cfg_dir_i,
    output logic                                    cmd_valid_o,
    input  logic                                    cmd_ready_i,
    output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] cmd_ch_o,
    output logic [ADDR_W-1:0]                       cmd_addr_o,
    output logic [7:0]                              cmd_len_o,
    output logic                                    cmd_dir_o,
    input  logic                                    rsp_valid_i,
    input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] rsp_ch_i,
    input  logic                                    rsp_err_i,
    output logic [N_CH-1:0]                         done_o,
    output logic [N_CH-1:0]                         err_o
);
    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int OUT_W = $clog2(MAX_OUTST + 1);
    localparam int BPB   = DATA_W / 8;

    ch_state_t         st      [N_CH];
    logic [ADDR_W-1:0] addr_q  [N_CH];
    logic [LEN_W-1:0]  rem_q   [N_CH];
    logic [OUT_W-1:0]  outst_q [N_CH];
    logic [N_CH-1:0]   dir_q;

    logic [LEN_W-1:0]  rem_nx   [N_CH];
    logic [OUT_W-1:0]  outst_nx [N_CH];
    logic [N_CH-1:0]   elig, req, gnt, hs_hit, rsp_hit;
    logic [IDX_W-1:0]  gnt_idx;
    logic              hs;
    logic [8:0]        beats, hs_beats;

    assign hs       = cmd_valid_o & cmd_ready_i;
    assign hs_beats = {1'b0, cmd_len_o} + 9'd1;
    // While a command is pending the arbiter sees only its channel, so the
    // pointer advances past exactly the channel that handshakes.
    assign req      = cmd_valid_o ? (N_CH'(1) << cmd_ch_o) : elig;

    iob_dma_rr_arb #(.N(N_CH)) u_arb (
        .clk    (clk_i),
        .rst_n  (arst_n_i),
        .req    (req),
        .adv    (hs & cke_i),
        .gnt    (gnt),
        .gnt_idx(gnt_idx)
    );

    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            cfg_ready_o[c] = (st[c] == CH_IDLE);
            elig[c]        = (st[c] == CH_ISSUE) && (rem_q[c] != '0) &&
                             (outst_q[c] < OUT_W'(MAX_OUTST));
            hs_hit[c]      = hs && (cmd_ch_o == IDX_W'(c));
            rsp_hit[c]     = rsp_valid_i && (rsp_ch_i == IDX_W'(c)) && (outst_q[c] != '0);
            rem_nx[c]      = hs_hit[c] ? (rem_q[c] - LEN_W'(hs_beats)) : rem_q[c];
            outst_nx[c]    = outst_q[c];
            if (hs_hit[c] && !rsp_hit[c])      outst_nx[c] = outst_q[c] + 1'b1;
            else if (!hs_hit[c] && rsp_hit[c]) outst_nx[c] = outst_q[c] - 1'b1;
        end
    end

`ifdef IOB_DMA_SCHED_4K_EN
    logic [12:0] page_lim;
`endif

    always_comb begin
        beats = 9'(MAX_BURST);
        if (rem_q[gnt_idx] < LEN_W'(MAX_BURST)) beats = 9'(rem_q[gnt_idx]);
`ifdef IOB_DMA_SCHED_4K_EN
        page_lim = (13'(PAGE_BYTES) - {1'b0, addr_q[gnt_idx][11:0]}) / 13'(BPB);
        if (13'(beats) > page_lim) beats = 9'(page_lim);
`endif
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            cmd_valid_o <= 1'b0;
            cmd_ch_o    <= '0;
            cmd_addr_o  <= '0;
            cmd_len_o   <= '0;
            cmd_dir_o   <= 1'b0;
            done_o      <= '0;
            err_o       <= '0;
            dir_q       <= '0;
            for (int c = 0; c < N_CH; c++) begin
                st[c]      <= CH_IDLE;
                addr_q[c]  <= '0;
                rem_q[c]   <= '0;
                outst_q[c] <= '0;
            end
        end else if (cke_i) begin
            done_o <= '0;
            if (hs) begin
                cmd_valid_o <= 1'b0;
            end else if (!cmd_valid_o && |gnt) begin
                cmd_valid_o <= 1'b1;
                cmd_ch_o    <= gnt_idx;
                cmd_addr_o  <= addr_q[gnt_idx];
                cmd_len_o   <= 8'(beats - 9'd1);
                cmd_dir_o   <= dir_q[gnt_idx];
            end
            for (int c = 0; c < N_CH; c++) begin
                rem_q[c]   <= rem_nx[c];
                outst_q[c] <= outst_nx[c];
                if (hs_hit[c]) addr_q[c] <= addr_q[c] + ADDR_W'(hs_beats) * ADDR_W'(BPB);
                if (rsp_hit[c] && rsp_err_i) err_o[c] <= 1'b1;
                case (st[c])
                    CH_IDLE: if (cfg_valid_i[c]) begin
                        addr_q[c] <= cfg_addr_i[c*ADDR_W +: ADDR_W];
                        rem_q[c]  <= cfg_len_i[c*LEN_W +: LEN_W];
                        dir_q[c]  <= cfg_dir_i[c];
                        err_o[c]  <= 1'b0;
                        if (cfg_len_i[c*LEN_W +: LEN_W] == '0) done_o[c] <= 1'b1;
                        else                                   st[c]     <= CH_ISSUE;
                    end
                    CH_ISSUE: if (rem_nx[c] == '0) st[c] <= CH_DRAIN;
                    CH_DRAIN: if (outst_nx[c] == '0) begin
                        st[c]     <= CH_IDLE;
                        done_o[c] <= 1'b1;
                    end
                    default: st[c] <= CH_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_iob_dma_sched.sv
// Directed bench for iob_dma_sched with default parameters (4 channels, 32-bit data).
module tb_iob_dma_sched;

    logic        clk = 1'b0;
    logic        arst_n, cke;
    logic [3:0]  cfg_valid, cfg_ready, cfg_dir, done, err;
    logic [127:0] cfg_addr;
    logic [95:0] cfg_len;
    logic        cmd_valid, cmd_ready, cmd_dir, rsp_valid, rsp_err;
    logic [1:0]  cmd_ch, rsp_ch;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;

    int          checks = 0;
    int          errors = 0;
    int          q_ch[$];
    logic [31:0] q_addr[$];
    int          q_len[$];
    logic        q_dir[$];
    int          done_cnt [4] = '{default: 0};

    always #5 clk = ~clk;

    iob_dma_sched dut (
        .clk_i      (clk),
        .arst_n_i   (arst_n),
        .cke_i      (cke),
        .cfg_valid_i(cfg_valid),
        .cfg_ready_o(cfg_ready),
        .cfg_addr_i (cfg_addr),
        .cfg_len_i  (cfg_len),
        .cfg_dir_i  (cfg_dir),
        .cmd_valid_o(cmd_valid),
        .cmd_ready_i(cmd_ready),
        .cmd_ch_o   (cmd_ch),
        .cmd_addr_o (cmd_addr),
        .cmd_len_o  (cmd_len),
        .cmd_dir_o  (cmd_dir),
        .rsp_valid_i(rsp_valid),
        .rsp_ch_i   (rsp_ch),
        .rsp_err_i  (rsp_err),
        .done_o     (done),
        .err_o      (err)
    );

    // Record each command the cycle before its handshake edge, and count done pulses.
    always @(negedge clk) begin
        if (arst_n && cke && cmd_valid && cmd_ready) begin
            q_ch.push_back(int'(cmd_ch));
            q_addr.push_back(cmd_addr);
            q_len.push_back(int'(cmd_len));
            q_dir.push_back(cmd_dir);
        end
        for (int c = 0; c < 4; c++) if (done[c]) done_cnt[c] <= done_cnt[c] + 1;
    end

    task automatic do_reset;
        arst_n = 1'b0; cke = 1'b1; cfg_valid = '0; cfg_addr = '0; cfg_len = '0;
        cfg_dir = '0; cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_ch = '0; rsp_err = 1'b0;
        repeat (2) @(posedge clk);
        #1 arst_n = 1'b1;
    endtask

    task automatic set_cfg(input int ch, input logic [31:0] a, input int len, input logic d);
        cfg_addr[ch*32 +: 32] = a;
        cfg_len[ch*24 +: 24]  = len[23:0];
        cfg_dir[ch]           = d;
        cfg_valid[ch]         = 1'b1;
    endtask

    task automatic pulse_cfg;
        @(posedge clk); #1;
        cfg_valid = '0;
    endtask

    task automatic send_rsp(input int ch, input logic e);
        rsp_valid = 1'b1; rsp_ch = 2'(ch); rsp_err = e;
        @(posedge clk); #1;
        rsp_valid = 1'b0; rsp_err = 1'b0;
    endtask

    task automatic wait_q(input int n);
        int t = 0;
        while (q_ch.size() < n && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        if (q_ch.size() < n) begin
            checks++; errors++;
            $display("FAIL wait_cmd: got %0d cmds, required %0d", q_ch.size(), n);
        end
    endtask

    task automatic respond(input int from, input int to, input int err_idx);
        for (int k = from; k < to; k++) begin
            wait_q(k + 1);
            if (q_ch.size() > k) send_rsp(q_ch[k], k == err_idx);
        end
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if ({cfg_ready, cmd_valid, cmd_ch, cmd_addr, cmd_len, cmd_dir, done, err} !==
            {4'hF, 1'b0, 2'd0, 32'd0, 8'd0, 1'b0, 4'd0, 4'd0}) begin
            errors++;
            $display("FAIL reset_state: ready=%h vld=%b addr=%h len=%0d done=%h err=%h required ready=f rest 0",
                     cfg_ready, cmd_valid, cmd_addr, cmd_len, done, err);
        end
    endtask

    task automatic test_cke;
        do_reset();
        cke = 1'b0;
        set_cfg(0, 32'h100, 8, 1'b0);
        pulse_cfg();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (cfg_ready !== 4'hF || cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL cke_hold: ready=%h vld=%b required ready=f vld=0", cfg_ready, cmd_valid);
        end
        cke = 1'b1;
    endtask

    task automatic test_basic;
        int b = q_ch.size();
        int d = done_cnt[0];
        int exp_len [3] = '{15, 15, 7};
        logic [31:0] exp_addr [3] = '{32'h1000, 32'h1040, 32'h1080};
        do_reset();
        cmd_ready = 1'b1;
        set_cfg(0, 32'h1000, 40, 1'b0);
        pulse_cfg();
        respond(b, b + 2, -1);
        wait_q(b + 3);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (q_ch.size() <= b + i || q_len[b+i] !== exp_len[i] || q_addr[b+i] !== exp_addr[i] ||
                q_ch[b+i] !== 0) begin
                errors++;
                $display("FAIL basic_cmd%0d: len=%0d addr=%h required len=%0d addr=%h", i,
                         (q_len.size() > b + i) ? q_len[b+i] : -1,
                         (q_addr.size() > b + i) ? q_addr[b+i] : 32'hx, exp_len[i], exp_addr[i]);
            end
        end
        checks++;
        if (done_cnt[0] !== d) begin
            errors++;
            $display("FAIL basic_early_done: done count %0d required %0d", done_cnt[0], d);
        end
        respond(b + 2, b + 3, -1);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (done_cnt[0] !== d + 1 || cfg_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL basic_done: done count %0d ready %b required %0d 1", done_cnt[0], cfg_ready[0], d + 1);
        end
    endtask

    task automatic test_back_to_back;
        int b = q_ch.size();
        int d0 = done_cnt[0];
        int d1 = done_cnt[1];
        int exp_ch [4] = '{0, 1, 0, 1};
        logic [31:0] exp_addr [4] = '{32'h100, 32'h2000, 32'h140, 32'h2040};
        do_reset();
        cmd_ready = 1'b1;
        set_cfg(0, 32'h100, 32, 1'b0);
        set_cfg(1, 32'h2000, 32, 1'b1);
        pulse_cfg();
        wait_q(b + 4);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (q_ch.size() <= b + i || q_ch[b+i] !== exp_ch[i] || q_addr[b+i] !== exp_addr[i] ||
                q_len[b+i] !== 15) begin
                errors++;
                $display("FAIL rr_cmd%0d: ch=%0d addr=%h required ch=%0d addr=%h len=15", i,
                         (q_ch.size() > b + i) ? q_ch[b+i] : -1,
                         (q_addr.size() > b + i) ? q_addr[b+i] : 32'hx, exp_ch[i], exp_addr[i]);
            end
        end
        respond(b, b + 4, -1);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done_cnt[0] !== d0 + 1 || done_cnt[1] !== d1 + 1) begin
            errors++;
            $display("FAIL rr_done: ch0 %0d ch1 %0d required %0d %0d", done_cnt[0], done_cnt[1], d0 + 1, d1 + 1);
        end
    endtask

    task automatic test_4k;
        int b = q_ch.size();
        int d = done_cnt[2];
        do_reset();
        cmd_ready = 1'b1;
        set_cfg(2, 32'h0FF0, 16, 1'b0);
        pulse_cfg();
`ifdef IOB_DMA_SCHED_4K_EN
        wait_q(b + 2);
        checks++;
        if (q_ch.size() < b + 2 || q_len[b] !== 3 || q_addr[b] !== 32'h0FF0 ||
            q_len[b+1] !== 11 || q_addr[b+1] !== 32'h1000) begin
            errors++;
            $display("FAIL page_split: size=%0d required len 3 @0ff0 then len 11 @1000", q_ch.size() - b);
        end
        respond(b, b + 2, -1);
`else
        wait_q(b + 1);
        checks++;
        if (q_ch.size() < b + 1 || q_len[b] !== 15 || q_addr[b] !== 32'h0FF0 || q_ch[b] !== 2) begin
            errors++;
            $display("FAIL page_nosplit: size=%0d required one len 15 @0ff0 ch2", q_ch.size() - b);
        end
        respond(b, b + 1, -1);
`endif
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done_cnt[2] !== d + 1) begin
            errors++;
            $display("FAIL page_done: done count %0d required %0d", done_cnt[2], d + 1);
        end
    endtask

    task automatic test_outstanding;
        int b = q_ch.size();
        int d = done_cnt[3];
        do_reset();
        cmd_ready = 1'b1;
        set_cfg(3, 32'h4000, 64, 1'b1);
        pulse_cfg();
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (q_ch.size() - b !== 2 || cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL outst_limit: cmds=%0d vld=%b required 2 0", q_ch.size() - b, cmd_valid);
        end
        respond(b, b + 1, -1);
        wait_q(b + 3);
        checks++;
        if (q_ch.size() < b + 3 || q_addr[b+2] !== 32'h4080 || q_dir[b+2] !== 1'b1) begin
            errors++;
            $display("FAIL outst_release: cmds=%0d required third at 4080 dir 1", q_ch.size() - b);
        end
        respond(b + 1, b + 4, -1);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done_cnt[3] !== d + 1 || q_ch.size() - b !== 4) begin
            errors++;
            $display("FAIL outst_done: done %0d cmds %0d required %0d 4", done_cnt[3], q_ch.size() - b, d + 1);
        end
    endtask

    task automatic test_len0_err;
        int b;
        int d;
        do_reset();
        cmd_ready = 1'b1;
        set_cfg(2, 32'h300, 0, 1'b0);
        pulse_cfg();
        checks++;
        if (done !== 4'b0100 || cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL len0_pulse: done=%b vld=%b required 0100 0", done, cmd_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 4'b0000 || cmd_valid !== 1'b0 || cfg_ready !== 4'hF) begin
            errors++;
            $display("FAIL len0_after: done=%b vld=%b ready=%h required 0000 0 f", done, cmd_valid, cfg_ready);
        end
        b = q_ch.size();
        d = done_cnt[1];
        set_cfg(1, 32'h500, 32, 1'b0);
        pulse_cfg();
        respond(b, b + 1, b);
        checks++;
        if (err !== 4'b0010 || cfg_ready[1] !== 1'b0) begin
            errors++;
            $display("FAIL err_set: err=%b ready1=%b required 0010 0", err, cfg_ready[1]);
        end
        respond(b + 1, b + 2, -1);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (done_cnt[1] !== d + 1 || err !== 4'b0010) begin
            errors++;
            $display("FAIL err_complete: done %0d err=%b required %0d 0010", done_cnt[1], err, d + 1);
        end
        set_cfg(1, 32'h600, 0, 1'b0);
        pulse_cfg();
        checks++;
        if (err !== 4'b0000) begin
            errors++;
            $display("FAIL err_clear: err=%b required 0000", err);
        end
    endtask

    task automatic test_reset_mid;
        int t = 0;
        int d = done_cnt[0];
        do_reset();
        cmd_ready = 1'b0;
        set_cfg(0, 32'h2000, 40, 1'b1);
        pulse_cfg();
        while (!cmd_valid && t < 10) begin
            @(posedge clk); #1;
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (cmd_valid !== 1'b1 || cmd_addr !== 32'h2000 || cmd_len !== 8'd15 || cmd_dir !== 1'b1 ||
            cmd_ch !== 2'd0) begin
            errors++;
            $display("FAIL cmd_hold: vld=%b addr=%h len=%0d dir=%b required 1 2000 15 1", cmd_valid, cmd_addr,
                     cmd_len, cmd_dir);
        end
        #2 arst_n = 1'b0;
        #1;
        checks++;
        if ({cfg_ready, cmd_valid, cmd_ch, cmd_addr, cmd_len, cmd_dir, done, err} !==
            {4'hF, 1'b0, 2'd0, 32'd0, 8'd0, 1'b0, 4'd0, 4'd0}) begin
            errors++;
            $display("FAIL async_reset: ready=%h vld=%b addr=%h len=%0d dir=%b required ready=f rest 0",
                     cfg_ready, cmd_valid, cmd_addr, cmd_len, cmd_dir);
        end
        @(posedge clk); #1;
        arst_n = 1'b1;
        send_rsp(0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (err !== 4'b0000 || done_cnt[0] !== d || cmd_valid !== 1'b0 || cfg_ready !== 4'hF) begin
            errors++;
            $display("FAIL stale_rsp: err=%b done %0d vld=%b required 0000 %0d 0", err, done_cnt[0], cmd_valid, d);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_cke();
        test_basic();
        test_back_to_back();
        test_4k();
        test_outstanding();
        test_len0_err();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
